// File: rtl/word_unpacker.sv
// -----------------------------------------------------------------------------
// word_unpacker
//
// Width down-converter. Each IN_WIDTH word accepted on the input handshake is
// replayed as RATIO consecutive OUT_WIDTH beats, most-significant slice first.
// This is the read-side inverse of the packing registers, for example one
// 32-bit word split back into two 16-bit halves.
//
// Handshake rule used on both sides: a transfer happens on a rising clk edge
// where valid & ready are both high. A producer that raises valid keeps its
// data stable until that edge. out_valid never depends combinationally on
// out_ready. in_ready does depend combinationally on out_ready, so a new word
// can be taken in the same cycle the last beat of the old one leaves.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_data    packed word; beat 0 = in_data[IN_WIDTH-1 -: OUT_WIDTH]
//   in_valid   in_data valid
//   in_ready   word accepted on an edge where in_valid & in_ready
//   out_data   current beat
//   out_valid  out_data valid
//   out_ready  beat accepted on an edge where out_valid & out_ready
//   out_last   high with the final beat (beat RATIO-1) of a word
//   beat_idx   index of the current beat, 0..RATIO-1
// -----------------------------------------------------------------------------
module word_unpacker #(
  parameter int OUT_WIDTH = 16,
  parameter int RATIO     = 2,
  parameter int IN_WIDTH  = OUT_WIDTH * RATIO
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_WIDTH-1:0]        in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(RATIO)-1:0]   beat_idx
);

  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if (RATIO < 2) begin : g_bad_ratio
      $error("word_unpacker: RATIO must be at least 2");
    end
    if (IN_WIDTH != OUT_WIDTH * RATIO) begin : g_bad_in_width
      $error("word_unpacker: IN_WIDTH must equal OUT_WIDTH*RATIO");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  word_q,  word_d;
  logic [IDX_W-1:0]     beat_q,  beat_d;
  logic                 is_last;

  // State register. Reset wins over any handshake on the same edge, so a
  // partially emitted word is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    beat_d    = beat_q;
    is_last   = (beat_q == LAST_IDX);
    out_valid = (state_q == SEND);
    out_last  = (state_q == SEND) && is_last;
    // Ready in IDLE, or while the final beat is leaving this very cycle.
    in_ready  = (state_q == IDLE) || ((state_q == SEND) && is_last && out_ready);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (is_last) begin
            if (in_valid) begin
              // Back-to-back word: restart at beat 0 with no idle cycle.
              word_d = in_data;
              beat_d = '0;
            end else begin
              beat_d  = '0;
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Beat selection: slice beat_q counted down from the top of the word.
  // Beat indices never exceed RATIO-1, so the default only matters in reset.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (beat_q == IDX_W'(i)) begin
        out_data = word_q[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
      end
    end
  end

  assign beat_idx = beat_q;

endmodule

// File: tb/tb_word_unpacker.sv
module tb_word_unpacker;

  // Instance 1: default geometry (2 x 16 bit).
  localparam int OW  = 16;
  localparam int R   = 2;
  localparam int IW  = OW * R;
  localparam int BW  = $clog2(R);
  // Instance 2: 4 x 8 bit.
  localparam int OW2 = 8;
  localparam int R2  = 4;
  localparam int IW2 = OW2 * R2;
  localparam int BW2 = $clog2(R2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- DUT signals ----------------
  logic [IW-1:0]  in_data;
  logic           in_valid, in_ready;
  logic [OW-1:0]  out_data;
  logic           out_valid, out_ready, out_last;
  logic [BW-1:0]  beat_idx;

  logic [IW2-1:0] in2_data;
  logic           in2_valid, in2_ready;
  logic [OW2-1:0] out2_data;
  logic           out2_valid, out2_ready, out2_last;
  logic [BW2-1:0] beat2_idx;

  word_unpacker #(.OUT_WIDTH(OW), .RATIO(R)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .beat_idx(beat_idx)
  );

  word_unpacker #(.OUT_WIDTH(OW2), .RATIO(R2)) dut4 (
    .clk(clk), .rst(rst),
    .in_data(in2_data), .in_valid(in2_valid), .in_ready(in2_ready),
    .out_data(out2_data), .out_valid(out2_valid), .out_ready(out2_ready),
    .out_last(out2_last), .beat_idx(beat2_idx)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // Entry layout: {last, beat index, data}
  logic [OW+BW:0]   exp_q[$];
  logic [OW2+BW2:0] exp2_q[$];
  int sz, sz2;

  // Reference model: a word becomes R beats, top slice first.
  function automatic void push_word(input logic [IW-1:0] w);
    for (int i = 0; i < R; i++) begin
      logic [OW-1:0] d;
      d = OW'(w >> ((R - 1 - i) * OW));
      exp_q.push_back({(i == R - 1), BW'(i), d});
    end
  endfunction

  function automatic void push_word2(input logic [IW2-1:0] w);
    for (int i = 0; i < R2; i++) begin
      logic [OW2-1:0] d;
      d = OW2'(w >> ((R2 - 1 - i) * OW2));
      exp2_q.push_back({(i == R2 - 1), BW2'(i), d});
    end
  endfunction

  // Monitor for instance 1, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      checks++;
      if (out_valid !== (sz != 0)) begin
        errors++;
        $display("FAIL out_valid: got %b expected %b (t=%0t)", out_valid, (sz != 0), $time);
      end
      checks++;
      if (in_ready !== ((sz == 0) || (sz == 1 && out_ready))) begin
        errors++;
        $display("FAIL in_ready: got %b expected %b (t=%0t)", in_ready,
                 ((sz == 0) || (sz == 1 && out_ready)), $time);
      end
      if (out_valid && sz != 0) begin
        checks++;
        if ({out_last, beat_idx, out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL beat: got last=%b idx=%0d data=%h expected last=%b idx=%0d data=%h (t=%0t)",
                   out_last, beat_idx, out_data, exp_q[0][OW+BW], exp_q[0][OW+BW-1:OW],
                   exp_q[0][OW-1:0], $time);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) push_word(in_data);
    end
  end

  // Monitor for instance 2.
  always @(negedge clk) begin
    if (rst) begin
      exp2_q.delete();
    end else begin
      sz2 = exp2_q.size();
      checks++;
      if (out2_valid !== (sz2 != 0)) begin
        errors++;
        $display("FAIL out_valid_r4: got %b expected %b (t=%0t)", out2_valid, (sz2 != 0), $time);
      end
      checks++;
      if (in2_ready !== ((sz2 == 0) || (sz2 == 1 && out2_ready))) begin
        errors++;
        $display("FAIL in_ready_r4: got %b expected %b (t=%0t)", in2_ready,
                 ((sz2 == 0) || (sz2 == 1 && out2_ready)), $time);
      end
      if (out2_valid && sz2 != 0) begin
        checks++;
        if ({out2_last, beat2_idx, out2_data} !== exp2_q[0]) begin
          errors++;
          $display("FAIL beat_r4: got last=%b idx=%0d data=%h expected last=%b idx=%0d data=%h (t=%0t)",
                   out2_last, beat2_idx, out2_data, exp2_q[0][OW2+BW2], exp2_q[0][OW2+BW2-1:OW2],
                   exp2_q[0][OW2-1:0], $time);
        end
        if (out2_ready) void'(exp2_q.pop_front());
      end
      if (in2_valid && in2_ready) push_word2(in2_data);
    end
  end

  // Random back-pressure generators.
  logic rand_ready  = 1'b0;
  logic rand_ready2 = 1'b0;
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end
  always @(posedge clk) begin
    if (rand_ready2) begin
      #1 out2_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the word is taken.
  task automatic send_word(input logic [IW-1:0] w);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1 within 300 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word2(input logic [IW2-1:0] w);
    int n;
    n = 0;
    in2_data  = w;
    in2_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in2_ready && n < 300);
    checks++;
    if (!in2_ready) begin
      errors++;
      $display("FAIL send_timeout_r4: in_ready stayed %b, expected 1 within 300 cycles", in2_ready);
    end
    @(posedge clk);
    #1;
    in2_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain2();
    int n;
    n = 0;
    while ((exp2_q.size() != 0 || out2_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp2_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout_r4: %0d beats still expected, required 0", exp2_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_regs(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
        beat_idx !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h last=%b idx=%0d in_ready=%b expected 0/0000/0/0/1",
               name, out_valid, out_data, out_last, beat_idx, in_ready);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 32'h1234_5678;
    out_ready  = 1'b0;
    in2_valid  = 1'b1;
    in2_data   = 32'h5566_7788;
    out2_ready = 1'b0;

    // Reset held 2 cycles with in_valid high: must be ignored.
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in2_valid = 1'b0;
    @(negedge clk);
    check_idle_regs("reset_state");
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    // Single word.
    send_word(32'hDEAD_BEEF);
    wait_drain();

    // Back-to-back words, no bubble expected.
    send_word(32'h1111_2222);
    send_word(32'h3333_4444);
    wait_drain();

    // Back-pressure on beat 0 for 3 cycles.
    out_ready = 1'b0;
    send_word(32'hCAFE_F00D);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a word: beat 0 consumed, beat 1 discarded.
    send_word(32'hAAAA_5555);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_regs("reset_mid_word");
    repeat (3) @(posedge clk);
    #1;

    // Random words, random gaps, random back-pressure.
    rand_ready = 1'b1;
    repeat (200) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send_word($urandom);
    end
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b1;
    wait_drain();

    // RATIO=4, OUT_WIDTH=8 instance.
    out2_ready = 1'b1;
    send_word2(32'h0102_0304);
    wait_drain2();
    rand_ready2 = 1'b1;
    repeat (40) begin
      int gap;
      gap = $urandom_range(0, 1);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send_word2($urandom);
    end
    rand_ready2 = 1'b0;
    #2;
    out2_ready = 1'b1;
    wait_drain2();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
